// File: rtl/phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : phase_ctrl
//  Description : Phase sequencer for the multicycle core. Drives the one-hot
//                phase vector {w,m,x,r,f} so that each phase bit is high for
//                exactly one cycle per instruction. Memory wait states are
//                inserted before F (instruction fetch) and before M (data
//                access). The M phase is skipped for non-memory instructions.
//                The block also handles run/halt control and traps memory
//                timeouts into a sticky bus-error state.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                run          - level, start/continue execution
//                halt_req     - decoded halt, sampled in X
//                mem_op       - instruction needs data memory, sampled in X
//                mem_ack      - memory completion, honoured only during a request
//                phase[4:0]   - one-hot {w,m,x,r,f}
//                mem_req      - memory request active
//                mem_fetch    - 1 = fetch request, 0 = data request
//                retire       - one-cycle pulse in W
//                halted       - high in HALT
//                bus_err      - sticky, high in ERR
//                cycles       - perf cycle counter (PHASE_PERF_EN only)
//                instret      - perf retired-instruction counter (PHASE_PERF_EN only)
//  Options     : PHASE_PERF_EN - when defined, builds the cycles/instret
//                counters; otherwise both read as constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        halt_req,
    input  logic        mem_op,
    input  logic        mem_ack,
    output logic [4:0]  phase,
    output logic        mem_req,
    output logic        mem_fetch,
    output logic        retire,
    output logic        halted,
    output logic        bus_err,
    output logic [31:0] cycles,
    output logic [31:0] instret
);

    localparam logic [3:0] c_ST_IDLE = 4'd0;
    localparam logic [3:0] c_ST_FREQ = 4'd1;
    localparam logic [3:0] c_ST_F    = 4'd2;
    localparam logic [3:0] c_ST_R    = 4'd3;
    localparam logic [3:0] c_ST_X    = 4'd4;
    localparam logic [3:0] c_ST_MREQ = 4'd5;
    localparam logic [3:0] c_ST_M    = 4'd6;
    localparam logic [3:0] c_ST_W    = 4'd7;
    localparam logic [3:0] c_ST_HALT = 4'd8;
    localparam logic [3:0] c_ST_ERR  = 4'd9;

    // Counter value seen during the last allowed request cycle; the counter
    // holds (request cycle number - 1).
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [3:0]      r_state;
    logic [3:0]      w_state_nxt;
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_nxt;
    logic            r_halt_pend;

    logic [4:0]      r_phase;
    logic            r_mem_req;
    logic            r_mem_fetch;
    logic            r_retire;
    logic            r_halted;
    logic            r_bus_err;

    // Next-state and timeout-counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_to_nxt    = r_to_cnt;
        case (r_state)
            c_ST_IDLE: if (run) w_state_nxt = c_ST_FREQ;
            c_ST_FREQ: begin
                // An ack in the expiry cycle still counts as success.
                if (mem_ack)                    w_state_nxt = c_ST_F;
                else if (r_to_cnt == c_TO_LAST) w_state_nxt = c_ST_ERR;
                else                            w_to_nxt    = r_to_cnt + 1'b1;
            end
            c_ST_F:    w_state_nxt = c_ST_R;
            c_ST_R:    w_state_nxt = c_ST_X;
            c_ST_X:    w_state_nxt = mem_op ? c_ST_MREQ : c_ST_W;
            c_ST_MREQ: begin
                if (mem_ack)                    w_state_nxt = c_ST_M;
                else if (r_to_cnt == c_TO_LAST) w_state_nxt = c_ST_ERR;
                else                            w_to_nxt    = r_to_cnt + 1'b1;
            end
            c_ST_M:    w_state_nxt = c_ST_W;
            c_ST_W: begin
                if (r_halt_pend) w_state_nxt = c_ST_HALT;
                else if (!run)   w_state_nxt = c_ST_IDLE;
                else             w_state_nxt = c_ST_FREQ;
            end
            // run must fall before a halted core can be restarted
            c_ST_HALT: if (!run) w_state_nxt = c_ST_IDLE;
            c_ST_ERR:  w_state_nxt = c_ST_ERR;
            default:   w_state_nxt = c_ST_IDLE;
        endcase

        // Every fresh request starts counting from zero
        if ((w_state_nxt == c_ST_FREQ || w_state_nxt == c_ST_MREQ) && (w_state_nxt != r_state))
            w_to_nxt = '0;
    end

    // State register with outputs registered from the next state, so each
    // output is aligned with the state it belongs to and has no input path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_to_cnt    <= '0;
            r_halt_pend <= 1'b0;
            r_phase     <= 5'b00000;
            r_mem_req   <= 1'b0;
            r_mem_fetch <= 1'b0;
            r_retire    <= 1'b0;
            r_halted    <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_nxt;

            if (r_state == c_ST_X)      r_halt_pend <= halt_req;
            else if (r_state == c_ST_W) r_halt_pend <= 1'b0;

            r_phase[0]  <= (w_state_nxt == c_ST_F);
            r_phase[1]  <= (w_state_nxt == c_ST_R);
            r_phase[2]  <= (w_state_nxt == c_ST_X);
            r_phase[3]  <= (w_state_nxt == c_ST_M);
            r_phase[4]  <= (w_state_nxt == c_ST_W);
            r_mem_req   <= (w_state_nxt == c_ST_FREQ) || (w_state_nxt == c_ST_MREQ);
            r_mem_fetch <= (w_state_nxt == c_ST_FREQ);
            r_retire    <= (w_state_nxt == c_ST_W);
            r_halted    <= (w_state_nxt == c_ST_HALT);
            r_bus_err   <= (w_state_nxt == c_ST_ERR);
        end
    end

    assign phase     = r_phase;
    assign mem_req   = r_mem_req;
    assign mem_fetch = r_mem_fetch;
    assign retire    = r_retire;
    assign halted    = r_halted;
    assign bus_err   = r_bus_err;

`ifdef PHASE_PERF_EN
    logic [31:0] r_cycles;
    logic [31:0] r_instret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles  <= '0;
            r_instret <= '0;
        end else begin
            if (r_state != c_ST_IDLE && r_state != c_ST_HALT && r_state != c_ST_ERR)
                r_cycles <= r_cycles + 32'd1;
            if (r_state == c_ST_W)
                r_instret <= r_instret + 32'd1;
        end
    end

    assign cycles  = r_cycles;
    assign instret = r_instret;
`else
    assign cycles  = 32'd0;
    assign instret = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_ctrl
//  Description : Self-checking bench for phase_ctrl. Directed scenarios and a
//                randomized run are compared every cycle against a
//                behavioural model of the instruction sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        halt_req = 1'b0;
    logic        mem_op = 1'b0;
    logic        mem_ack = 1'b0;
    logic [4:0]  phase;
    logic        mem_req;
    logic        mem_fetch;
    logic        retire;
    logic        halted;
    logic        bus_err;
    logic [31:0] cycles;
    logic [31:0] instret;

    int tests = 0;
    int fails = 0;

    phase_ctrl #(.MEM_TIMEOUT(TMO), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .mem_op(mem_op),
        .mem_ack(mem_ack), .phase(phase), .mem_req(mem_req), .mem_fetch(mem_fetch),
        .retire(retire), .halted(halted), .bus_err(bus_err),
        .cycles(cycles), .instret(instret)
    );

    always #5 clk = ~clk;

    // Reference model: where the instruction currently is
    typedef enum int {M_IDLE, M_FETCHWAIT, M_F, M_R, M_X, M_DATAWAIT, M_M, M_W, M_HALT, M_ERR} mph_t;
    mph_t        m_st = M_IDLE;
    int          m_wait = 0;       // request cycles already spent without ack
    logic        m_halt = 1'b0;
    logic [31:0] m_cyc = 0;
    logic [31:0] m_ins = 0;

    task automatic model_step();
        if (rst) begin
            m_st = M_IDLE; m_wait = 0; m_halt = 1'b0; m_cyc = 0; m_ins = 0;
        end else begin
            if (m_st != M_IDLE && m_st != M_HALT && m_st != M_ERR) m_cyc = m_cyc + 1;
            if (m_st == M_W) m_ins = m_ins + 1;
            case (m_st)
                M_IDLE: if (run) begin m_st = M_FETCHWAIT; m_wait = 0; end
                M_FETCHWAIT, M_DATAWAIT: begin
                    if (mem_ack) m_st = (m_st == M_FETCHWAIT) ? M_F : M_M;
                    else if (m_wait + 1 == TMO) m_st = M_ERR;
                    else m_wait = m_wait + 1;
                end
                M_F: m_st = M_R;
                M_R: m_st = M_X;
                M_X: begin
                    m_halt = halt_req;
                    if (mem_op) begin m_st = M_DATAWAIT; m_wait = 0; end
                    else m_st = M_W;
                end
                M_M: m_st = M_W;
                M_W: begin
                    if (m_halt) begin m_st = M_HALT; m_halt = 1'b0; end
                    else if (!run) m_st = M_IDLE;
                    else begin m_st = M_FETCHWAIT; m_wait = 0; end
                end
                M_HALT: if (!run) m_st = M_IDLE;
                default: m_st = M_ERR;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h (model phase %s)", tag, got, exp, m_st.name());
        end
    endtask

    task automatic check_all();
        logic [4:0] e_ph;
        e_ph = 5'b0;
        if (m_st == M_F) e_ph = 5'b00001;
        if (m_st == M_R) e_ph = 5'b00010;
        if (m_st == M_X) e_ph = 5'b00100;
        if (m_st == M_M) e_ph = 5'b01000;
        if (m_st == M_W) e_ph = 5'b10000;
        chk("phase",     32'(phase),     32'(e_ph));
        chk("mem_req",   32'(mem_req),   32'(m_st == M_FETCHWAIT || m_st == M_DATAWAIT));
        chk("mem_fetch", 32'(mem_fetch), 32'(m_st == M_FETCHWAIT));
        chk("retire",    32'(retire),    32'(m_st == M_W));
        chk("halted",    32'(halted),    32'(m_st == M_HALT));
        chk("bus_err",   32'(bus_err),   32'(m_st == M_ERR));
`ifdef PHASE_PERF_EN
        chk("cycles",    cycles,  m_cyc);
        chk("instret",   instret, m_ins);
`else
        chk("cycles",    cycles,  32'd0);
        chk("instret",   instret, 32'd0);
`endif
    endtask

    // One clock: inputs applied at the falling edge, model advanced at the
    // rising edge, outputs compared 1 time unit later.
    task automatic step(input logic r, input logic h, input logic mo, input logic ma, input logic rs);
        run = r; halt_req = h; mem_op = mo; mem_ack = ma; rst = rs;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        logic a;
        @(negedge clk);

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);

        // Zero-wait, non-memory stream: 4 instructions plus the IDLE cycle
        for (int i = 0; i < 21; i++) step(1, 0, 0, 1, 0);
`ifdef PHASE_PERF_EN
        chk("cycles_after_4", cycles, 32'd20);
        chk("instret_after_4", instret, 32'd4);
`endif

        // Drop run during R: instruction completes, then IDLE
        for (int i = 0; i < 10 && m_st != M_F; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);                        // now in R
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
        chk("idle_after_drop", 32'(m_st == M_IDLE), 32'd1);

        // Memory instruction: fetch ack after 3 waits (boundary), data after 2
        for (int i = 0; i < 24; i++) begin
            a = (m_st == M_FETCHWAIT && m_wait == 3) || (m_st == M_DATAWAIT && m_wait == 2);
            step(1, 0, 1, a, 0);
        end

        // Halt: halt_req in X, stay halted while run=1, restart via run toggle
        for (int i = 0; i < 12 && m_st != M_R; i++) step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);                        // enters X
        step(1, 1, 0, 1, 0);                        // X samples halt_req
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);

        // Timeout: no fetch ack -> ERR, held until reset
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
        chk("err_sticky", 32'(bus_err), 32'd1);
        step(1, 0, 0, 1, 1);

        // Reset during a data wait; a late ack afterwards is ignored
        for (int i = 0; i < 20 && !(m_st == M_DATAWAIT && m_wait == 1); i++)
            step(1, 0, 1, (m_st != M_DATAWAIT), 0);
        step(1, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);

        // Randomized run
        for (int i = 0; i < 600; i++) begin
            logic r, h, mo, ma, rs;
            r  = ($urandom_range(0, 7) != 0);
            h  = ($urandom_range(0, 9) == 0);
            mo = $urandom_range(0, 1) == 1;
            ma = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 99) == 0) || (m_st == M_ERR && $urandom_range(0, 3) == 0);
            step(r, h, mo, ma, rs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
